multi_clock_divider: RTL and testbench

Parametrised successor to the single-channel clock divider. It generates NUM_CH independent ~50%-duty clock outputs from clk, each at a per-channel frequency given in Hz. One shared sequential divider computes each channel's period in the background, so there is no combinational divide. New rates are applied glitch-free at period boundaries. Adds per-channel enable, a rising-edge tick strobe, phase resync and speed=0 handling.

---
 rtl/clkgen_pkg.sv | 17 +
 rtl/seq_divider.sv | 63 ++++++
 rtl/multi_clock_divider.sv | 201 ++++++++++++++++++++
 tb/tb_multi_clock_divider.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared definitions for the multi-channel clock generator.
//   div_state_t : state encoding of the shared divider scheduler
//   DEF_*       : default dividend / field widths used by the top and the divider
package clkgen_pkg;

   localparam int DEF_BASE_HZ = 50_000_000;
   localparam int DEF_SPEED_W = 20;
   localparam int DEF_CNT_W   = 26;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Computes BASE_HZ / divisor over CNT_W iterations after a start pulse.
//   clk, reset_n : clock, async active-low reset
//   start        : load operands (divisor captured here)
//   divisor      : zero-extended divisor, must be non-zero
//   done         : high during the last iteration; quotient is final the cycle after
//   quotient     : result, held until the next start
module seq_divider
   import clkgen_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int BASE_HZ = DEF_BASE_HZ
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] divisor,
   output logic             done,
   output logic [CNT_W-1:0] quotient
);

   localparam int               STEP_W   = $clog2(CNT_W + 1);
   localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(BASE_HZ);

   logic [CNT_W-1:0]  rem;
   logic [CNT_W-1:0]  dvs;
   logic [STEP_W-1:0] steps;
   logic [CNT_W:0]    trial;
   logic [CNT_W-1:0]  diff;

   // The quotient register doubles as the dividend shift register: dividend
   // bits leave at the top while quotient bits enter at the bottom.
   always_comb begin
      trial = {rem, quotient[CNT_W-1]};
      diff  = trial[CNT_W-1:0] - dvs;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem      <= '0;
         dvs      <= '0;
         quotient <= '0;
         steps    <= '0;
      end else if (start) begin
         rem      <= '0;
         dvs      <= divisor;
         quotient <= DIVIDEND;
         steps    <= STEP_W'(CNT_W);
      end else if (steps != '0) begin
         if (trial >= {1'b0, dvs}) begin
            rem      <= diff;
            quotient <= {quotient[CNT_W-2:0], 1'b1};
         end else begin
            rem      <= trial[CNT_W-1:0];
            quotient <= {quotient[CNT_W-2:0], 1'b0};
         end
         steps <= steps - STEP_W'(1);
      end
   end

   assign done = (steps == STEP_W'(1));

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent ~50% duty clock outputs derived from clk, each at a
// requested frequency in Hz. Periods are computed one channel at a time by a
// shared sequential divider and applied at period boundaries.
//   clk, reset_n : clock, async active-low reset
//   speed        : requested Hz per channel, channel i at [i*SPEED_W +: SPEED_W]
//   enable       : per-channel run enable
//   resync       : one-cycle pulse restarting every channel in phase
//   out_clk      : divided clocks (registered)
//   tick         : one-cycle pulse in the first high cycle of out_clk
//   period_valid : channel holds a computed period
//   busy         : shared divider computing
//
// Scheduler states:
//   state   | meaning
//   IDLE    | round-robin scan for a channel whose speed differs from its latched speed
//   LOAD    | latch speed; start divider, or shut the channel down when speed is 0
//   DIV     | divider iterating, CNT_W cycles
//   DONE    | write the clamped quotient as the new / pending period
module multi_clock_divider
   import clkgen_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int BASE_HZ = DEF_BASE_HZ,
   parameter int SPEED_W = DEF_SPEED_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_CH*SPEED_W-1:0] speed,
   input  logic [NUM_CH-1:0]         enable,
   input  logic                      resync,
   output logic [NUM_CH-1:0]         out_clk,
   output logic [NUM_CH-1:0]         tick,
   output logic [NUM_CH-1:0]         period_valid,
   output logic                      busy
);

   localparam int               CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);

   div_state_t        state;
   logic [CH_W-1:0]   sel;
   logic [CH_W-1:0]   last;
   logic [CH_W-1:0]   pick;
   logic [CH_W-1:0]   scan_idx;
   logic              found;

   logic [SPEED_W-1:0] spd_in      [NUM_CH];
   logic [SPEED_W-1:0] spd_latched [NUM_CH];
   logic [SPEED_W-1:0] spd_sel;
   logic               sel_zero;
   logic [NUM_CH-1:0]  need;

   logic [CNT_W-1:0]  period [NUM_CH];
   logic [CNT_W-1:0]  pend   [NUM_CH];
   logic [CNT_W-1:0]  cnt    [NUM_CH];
   logic [NUM_CH-1:0] pend_flag;
   logic [NUM_CH-1:0] run;
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] hi_half;
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] zero_hit;
   logic [NUM_CH-1:0] apply_wr;

   logic              div_start;
   logic              div_done;
   logic [CNT_W-1:0]  quotient;
   logic [CNT_W-1:0]  new_p;

   seq_divider #(
      .CNT_W   (CNT_W),
      .BASE_HZ (BASE_HZ)
   ) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .divisor  (CNT_W'(spd_sel)),
      .done     (div_done),
      .quotient (quotient)
   );

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         spd_in[i] = speed[i*SPEED_W +: SPEED_W];
         need[i]   = (spd_in[i] != spd_latched[i]);
      end
   end

   // Scan starts one past the last-served channel so no channel can starve.
   always_comb begin
      found    = 1'b0;
      pick     = last;
      scan_idx = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         scan_idx = CH_W'((int'(last) + k) % NUM_CH);
         if (!found && need[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx;
         end
      end
   end

   always_comb begin
      spd_sel   = spd_in[sel];
      sel_zero  = (spd_sel == '0);
      div_start = (state == ST_LOAD) && !sel_zero;
      // A speed-0 LOAD only shuts the channel down; the divider stays idle.
      busy      = (state == ST_DIV) || (state == ST_DONE) || div_start;
      new_p     = (quotient < MIN_P) ? MIN_P : quotient;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         sel   <= '0;
         last  <= CH_W'(NUM_CH - 1);
         for (int i = 0; i < NUM_CH; i++) spd_latched[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  sel   <= pick;
                  last  <= pick;
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               spd_latched[sel] <= spd_sel;
               state            <= sel_zero ? ST_IDLE : ST_DIV;
            end
            ST_DIV: begin
               if (div_done) state <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i]   = (state == ST_DONE) && (sel == CH_W'(i));
         zero_hit[i] = (state == ST_LOAD) && sel_zero && (sel == CH_W'(i));
         run[i]      = enable[i] && period_valid[i];
         wrap[i]     = run[i] && (cnt[i] >= period[i] - CNT_W'(1));
         hi_half[i]  = (cnt[i] >= (period[i] >> 1));
         // A fresh period can go live straight away whenever the channel is
         // not mid-period: not yet running, disabled, resyncing or wrapping.
         apply_wr[i] = wr_hit[i] &&
                       (!period_valid[i] || !enable[i] || resync || wrap[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            period[i] <= '0;
            pend[i]   <= '0;
            cnt[i]    <= '0;
         end
         pend_flag    <= '0;
         out_clk      <= '0;
         tick         <= '0;
         period_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (zero_hit[i]) begin
               period_valid[i] <= 1'b0;
               pend_flag[i]    <= 1'b0;
               cnt[i]          <= '0;
               out_clk[i]      <= 1'b0;
               tick[i]         <= 1'b0;
            end else begin
               if (apply_wr[i]) begin
                  period[i]       <= new_p;
                  period_valid[i] <= 1'b1;
                  pend_flag[i]    <= 1'b0;
               end else if (wr_hit[i]) begin
                  pend[i]      <= new_p;
                  pend_flag[i] <= 1'b1;
               end else if (pend_flag[i] && (resync || wrap[i] || !enable[i])) begin
                  period[i]    <= pend[i];
                  pend_flag[i] <= 1'b0;
               end

               if (resync || !run[i]) begin
                  cnt[i]     <= '0;
                  out_clk[i] <= 1'b0;
                  tick[i]    <= 1'b0;
               end else begin
                  cnt[i]     <= wrap[i] ? '0 : cnt[i] + CNT_W'(1);
                  out_clk[i] <= hi_half[i];
                  tick[i]    <= hi_half[i] && !out_clk[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

   localparam int NUM_CH  = 2;
   localparam int BASE_HZ = 100;
   localparam int SPEED_W = 8;
   localparam int CNT_W   = 8;

   logic                      clk;
   logic                      reset_n;
   logic [NUM_CH*SPEED_W-1:0] speed;
   logic [NUM_CH-1:0]         enable;
   logic                      resync;
   logic [NUM_CH-1:0]         out_clk;
   logic [NUM_CH-1:0]         tick;
   logic [NUM_CH-1:0]         period_valid;
   logic                      busy;

   int n_checks = 0;
   int n_fail   = 0;

   multi_clock_divider #(
      .NUM_CH  (NUM_CH),
      .BASE_HZ (BASE_HZ),
      .SPEED_W (SPEED_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .speed        (speed),
      .enable       (enable),
      .resync       (resync),
      .out_clk      (out_clk),
      .tick         (tick),
      .period_valid (period_valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_speed(input int s0, input int s1);
      speed = {SPEED_W'(s1), SPEED_W'(s0)};
   endtask

   // One window from a tick to the next tick: high run, then low run.
   task automatic measure(input int ch, output int hi, output int lo);
      int c;
      hi = 0;
      lo = 0;
      c  = 0;
      while (!tick[ch] && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (c >= 200) check_val("tick_timeout", 0, 1);
      while (out_clk[ch] && c < 400) begin
         hi++;
         @(negedge clk);
         c++;
      end
      while (!out_clk[ch] && c < 400) begin
         lo++;
         @(negedge clk);
         c++;
      end
   endtask

   initial begin
      int hi, lo, len, bad, seen_short, last_hi, last_lo, prev, first;
      int t0, t1, ticks, busy_seen, out_seen;

      reset_n = 1'b0;
      set_speed(0, 0);
      enable  = '0;
      resync  = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_out_clk", int'(out_clk), 0);
      check_val("rst_tick", int'(tick), 0);
      check_val("rst_valid", int'(period_valid), 0);
      check_val("rst_busy", int'(busy), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // speed 10 -> P=10; divider busy CNT_W+2 cycles
      enable = 2'b11;
      set_speed(10, 0);
      t0 = 0;
      while (!busy && t0 < 20) begin
         @(negedge clk);
         t0++;
      end
      len = 0;
      while (busy && len < 40) begin
         len++;
         @(negedge clk);
      end
      check_val("busy_len", len, 10);
      check_val("valid0_p10", int'(period_valid[0]), 1);
      measure(0, hi, lo);
      measure(0, hi, lo);
      check_val("p10_hi", hi, 5);
      check_val("p10_lo", lo, 5);

      // disable ch0: output low next cycle, period kept; restart counts from 0
      enable = 2'b10;
      @(negedge clk);
      check_val("dis_out_tick", int'({out_clk[0], tick[0]}), 0);
      check_val("dis_valid", int'(period_valid[0]), 1);
      repeat (3) @(negedge clk);
      enable = 2'b11;
      t0 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (tick[0] && t0 == 0) t0 = c;
      end
      check_val("reen_tick_at", t0, 6);

      // 10 -> 20 while cnt0=3: old period completes, then 2 low / 3 high, no runt
      measure(0, hi, lo);
      repeat (7) @(negedge clk);
      set_speed(20, 0);
      prev = int'(out_clk[0]);
      len = 0; first = 1; bad = 0; seen_short = 0; last_hi = 0; last_lo = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (int'(out_clk[0]) == prev) begin
            len++;
         end else begin
            if (!first) begin
               if (prev == 1) begin
                  if (len == 3) seen_short = 1;
                  else if (!(len == 5 && seen_short == 0)) bad++;
                  last_hi = len;
               end else begin
                  if (len == 2) seen_short = 1;
                  else if (!(len == 5 && seen_short == 0)) bad++;
                  last_lo = len;
               end
            end
            first = 0;
            prev  = int'(out_clk[0]);
            len   = 1;
         end
      end
      check_val("chg_bad_runs", bad, 0);
      check_val("chg_seen_short", seen_short, 1);
      check_val("p5_hi", last_hi, 3);
      check_val("p5_lo", last_lo, 2);

      // speed 3 -> P=33
      set_speed(3, 0);
      repeat (15) @(negedge clk);
      measure(0, hi, lo);
      measure(0, hi, lo);
      check_val("p33_hi", hi, 17);
      check_val("p33_lo", lo, 16);

      // speed 0: channel off, divider untouched
      set_speed(0, 0);
      busy_seen = 0;
      out_seen  = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (busy) busy_seen = 1;
         if (c >= 3 && out_clk[0]) out_seen = 1;
      end
      check_val("zero_valid", int'(period_valid[0]), 0);
      check_val("zero_busy", busy_seen, 0);
      check_val("zero_out", out_seen, 0);

      // speed 200 > BASE_HZ/2 -> P=2
      set_speed(200, 0);
      repeat (15) @(negedge clk);
      measure(0, hi, lo);
      measure(0, hi, lo);
      check_val("p2_hi", hi, 1);
      check_val("p2_lo", lo, 1);
      ticks = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (tick[0]) ticks++;
      end
      check_val("p2_ticks20", ticks, 10);

      // fresh scan after reset: ch0 then ch1 back-to-back, then resync
      set_speed(0, 0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      set_speed(10, 4);
      t0 = 0;
      t1 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (period_valid[0] && t0 == 0) t0 = c;
         if (period_valid[1] && t1 == 0) t1 = c;
      end
      check_val("dual_valid0_at", t0, 11);
      check_val("dual_valid1_at", t1, 22);
      resync = 1'b1;
      t0 = 0;
      t1 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check_val("resync_out", int'(out_clk), 0);
            resync = 1'b0;
         end
         if (tick[0] && t0 == 0) t0 = c;
         if (tick[1] && t1 == 0) t1 = c;
      end
      check_val("resync_tick0_at", t0, 7);
      check_val("resync_tick1_at", t1, 14);

      // async reset in the middle of a divide, then full recovery
      set_speed(3, 4);
      repeat (5) @(negedge clk);
      check_val("mid_div_busy", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1 check_val("async_rst_outs", int'({out_clk, tick, period_valid, busy}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      check_val("rec_valid", int'(period_valid), 3);
      measure(0, hi, lo);
      measure(0, hi, lo);
      check_val("rec_p33_hi", hi, 17);
      check_val("rec_p33_lo", lo, 16);
      measure(1, hi, lo);
      measure(1, hi, lo);
      check_val("rec_p25_hi", hi, 13);
      check_val("rec_p25_lo", lo, 12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
